wiener_n_channels: RTL and testbench

Parametrised N-channel block-adaptive Wiener denoiser for the video pipeline. It buffers one block of packed pixels and computes per-channel block mean and variance. A single shared serial divider derives a per-channel gain. The block then replays the stored block with each sample pulled toward its channel mean. It replaces the fixed 3-channel arrangement with a configurable channel count, a ready/valid input, a valid-flagged output, per-channel bypass and block-framing error detection.

---
 rtl/wiener_n_channels.sv | 214 +++++++++++++++++++++
 tb/tb_wiener_n_channels.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wiener_n_channels.sv
// N-channel block-adaptive Wiener denoiser: buffers one block, derives per-channel
// mean/variance and a gain with a shared serial divider, then replays the filtered block.

module wiener_lane #(
    parameter int CH_WIDTH  = 8,
    parameter int GAIN_FRAC = 8
) (
    input  logic [CH_WIDTH-1:0]  x,
    input  logic [CH_WIDTH-1:0]  mean,
    input  logic [GAIN_FRAC:0]   gain,
    input  logic                 bypass,
    output logic [CH_WIDTH-1:0]  y
);
    localparam int PW = CH_WIDTH + GAIN_FRAC + 3;
    localparam logic signed [PW-1:0] Y_MAX = PW'((1 << CH_WIDTH) - 1);

    logic signed [PW-1:0] diff, prod, yy;

    always_comb begin
        diff = $signed({{(PW-CH_WIDTH){1'b0}}, x}) - $signed({{(PW-CH_WIDTH){1'b0}}, mean});
        prod = diff * $signed({{(PW-GAIN_FRAC-1){1'b0}}, gain});
        yy   = $signed({{(PW-CH_WIDTH){1'b0}}, mean}) + (prod >>> GAIN_FRAC);
        if (bypass)         y = x;
        else if (yy[PW-1])  y = '0;
        else if (yy > Y_MAX) y = '1;
        else                y = yy[CH_WIDTH-1:0];
    end
endmodule

module wiener_n_channels #(
    parameter int CHANNELS      = 3,
    parameter int CH_WIDTH      = 8,
    parameter int TOTAL_SAMPLES = 64,
    parameter int GAIN_FRAC     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_of_frame,
    input  logic                         start_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*CH_WIDTH-1:0] data_in,
    input  logic [2*CH_WIDTH-1:0]        noise_variance,
    input  logic [CHANNELS-1:0]          bypass_mask,
    output logic                         out_valid,
    output logic [CHANNELS*CH_WIDTH-1:0] data_out,
    output logic [31:0]                  data_count,
    output logic                         err_framing
);
    localparam int DW    = CHANNELS * CH_WIDTH;
    localparam int LOG2N = $clog2(TOTAL_SAMPLES);
    localparam int SW    = CH_WIDTH + LOG2N;
    localparam int QW    = 2 * CH_WIDTH + LOG2N;
    localparam int VW    = 2 * CH_WIDTH;
    localparam int GW    = GAIN_FRAC + 1;
    localparam int BW    = $clog2(GAIN_FRAC + 1);
    localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(TOTAL_SAMPLES - 1);
    localparam logic [BW-1:0]    LAST_BIT = BW'(GAIN_FRAC);
    localparam logic [CW-1:0]    LAST_CH  = CW'(CHANNELS - 1);
    localparam logic [GW-1:0]    GAIN_ONE = GW'(2 ** GAIN_FRAC);

    typedef enum logic [1:0] {COLLECT, STATS, DIVIDE, OUTPUT} state_t;
    state_t state, state_nx;

    logic                 armed, accept, take, sample_start, last_sample;
    logic [LOG2N-1:0]     wr_idx, wr_addr, out_idx, rd_idx;
    logic [DW-1:0]        mem [TOTAL_SAMPLES];
    logic [DW-1:0]        rd_pix, y_pix;

    logic [CHANNELS-1:0][CH_WIDTH-1:0] mean_s, mean_q;
    logic [CHANNELS-1:0][VW-1:0]       var_s, var_q, sv_s, sv_q;
    logic [CHANNELS-1:0]               byp_q;
    logic [CHANNELS-1:0][GW-1:0]       gain_q, gain_nx;

    logic [CW-1:0]  div_ch;
    logic [BW-1:0]  div_bit;
    logic [VW-1:0]  rem, d_var, d_sv, r_prev;
    logic [VW:0]    r_sh, r_sub;
    logic [GW-1:0]  quo, q_base, q_nx;
    logic           q_bit, bit_last, div_done, emit;

    assign in_ready     = (state == COLLECT);
    assign accept       = in_valid && in_ready;
    assign sample_start = accept && start_data;
    assign take         = sample_start || (accept && armed);
    assign wr_addr      = sample_start ? '0 : wr_idx;
    assign last_sample  = take && (wr_addr == LAST_IDX);

    assign bit_last = (div_bit == LAST_BIT);
    assign div_done = (state == DIVIDE) && bit_last && (div_ch == LAST_CH);
    assign emit     = div_done || ((state == OUTPUT) && (out_idx != LAST_IDX));
    assign rd_idx   = (state == OUTPUT) ? out_idx + LOG2N'(1) : '0;

    always_ff @(posedge clk) begin
        if (take) mem[wr_addr] <= data_in;
    end
    assign rd_pix = mem[rd_idx];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [CH_WIDTH-1:0] x;
        logic [VW-1:0]       x2, msq, m2;
        logic [SW-1:0]       acc_sum;
        logic [QW-1:0]       acc_sq;

        assign x  = data_in[c*CH_WIDTH +: CH_WIDTH];
        assign x2 = {{CH_WIDTH{1'b0}}, x} * {{CH_WIDTH{1'b0}}, x};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc_sum <= '0;
                acc_sq  <= '0;
            end else if (take) begin
                if (wr_addr == '0) begin
                    acc_sum <= {{LOG2N{1'b0}}, x};
                    acc_sq  <= {{LOG2N{1'b0}}, x2};
                end else begin
                    acc_sum <= acc_sum + {{LOG2N{1'b0}}, x};
                    acc_sq  <= acc_sq + {{LOG2N{1'b0}}, x2};
                end
            end
        end

        assign mean_s[c] = acc_sum[SW-1:LOG2N];
        assign msq       = acc_sq[QW-1:LOG2N];
        assign m2        = {{CH_WIDTH{1'b0}}, mean_s[c]} * {{CH_WIDTH{1'b0}}, mean_s[c]};
        assign var_s[c]  = (msq > m2) ? msq - m2 : '0;
        assign sv_s[c]   = (var_s[c] > noise_variance) ? var_s[c] - noise_variance : '0;

        wiener_lane #(.CH_WIDTH(CH_WIDTH), .GAIN_FRAC(GAIN_FRAC)) u_lane (
            .x      (rd_pix[c*CH_WIDTH +: CH_WIDTH]),
            .mean   (mean_q[c]),
            .gain   (gain_nx[c]),
            .bypass (byp_q[c]),
            .y      (y_pix[c*CH_WIDTH +: CH_WIDTH])
        );
    end

    // Only GAIN_FRAC+1 quotient bits exist because sv <= var, so the remainder
    // starts at sv>>1 and the single dividend bit shifted in is sv[0].
    always_comb begin
        d_var   = var_q[div_ch];
        d_sv    = sv_q[div_ch];
        r_prev  = (div_bit == '0) ? (d_sv >> 1) : rem;
        r_sh    = {r_prev, (div_bit == '0) ? d_sv[0] : 1'b0};
        q_bit   = (r_sh >= {1'b0, d_var});
        r_sub   = q_bit ? r_sh - {1'b0, d_var} : r_sh;
        q_base  = (div_bit == '0) ? '0 : quo;
        q_nx    = {q_base[GW-2:0], q_bit};
        gain_nx = gain_q;
        if ((state == DIVIDE) && bit_last)
            gain_nx[div_ch] = (d_var == '0) ? '0 : ((q_nx > GAIN_ONE) ? GAIN_ONE : q_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= COLLECT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: if (last_sample) state_nx = STATS;
            STATS:   state_nx = DIVIDE;
            DIVIDE:  if (div_done) state_nx = OUTPUT;
            OUTPUT:  if (out_idx == LAST_IDX) state_nx = COLLECT;
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;      wr_idx <= '0;     err_framing <= 1'b0;
            mean_q <= '0;       var_q <= '0;      sv_q <= '0;        byp_q <= '0;
            div_ch <= '0;       div_bit <= '0;    rem <= '0;         quo <= '0;
            gain_q <= '0;       out_idx <= '0;    out_valid <= 1'b0; data_out <= '0;
            data_count <= '0;
        end else begin
            if (take) wr_idx <= wr_addr + LOG2N'(1);
            if (sample_start) armed <= 1'b1;
            if (start_of_frame) err_framing <= 1'b0;
            if (sample_start && (wr_idx != '0)) err_framing <= 1'b1;

            if (state == STATS) begin
                mean_q <= mean_s;
                var_q  <= var_s;
                sv_q   <= sv_s;
                byp_q  <= bypass_mask;
            end

            if (state == DIVIDE) begin
                rem <= r_sub[VW-1:0];
                quo <= q_nx;
                if (bit_last) begin
                    div_bit <= '0;
                    div_ch  <= (div_ch == LAST_CH) ? '0 : div_ch + CW'(1);
                end else begin
                    div_bit <= div_bit + BW'(1);
                end
            end else begin
                div_ch  <= '0;
                div_bit <= '0;
            end
            gain_q <= gain_nx;

            out_valid <= emit;
            data_out  <= emit ? y_pix : '0;
            if (emit) out_idx <= rd_idx;

            if (start_of_frame) data_count <= {31'd0, out_valid};
            else if (out_valid) data_count <= data_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_wiener_n_channels.sv
// Directed bench for wiener_n_channels: block-level reference model plus a per-cycle
// output/data_count comparator, with literal pins for latency and known pixels.

module tb_wiener_n_channels;
    localparam int CH = 3;
    localparam int W  = 8;
    localparam int N  = 64;
    localparam int GF = 8;

    logic            clk, rst_n, start_of_frame, start_data, in_valid, in_ready;
    logic [CH*W-1:0] data_in, data_out;
    logic [2*W-1:0]  noise_variance;
    logic [CH-1:0]   bypass_mask;
    logic            out_valid, err_framing;
    logic [31:0]     data_count;

    wiener_n_channels #(.CHANNELS(CH), .CH_WIDTH(W), .TOTAL_SAMPLES(N), .GAIN_FRAC(GF)) dut (
        .clk(clk), .rst_n(rst_n), .start_of_frame(start_of_frame), .start_data(start_data),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .noise_variance(noise_variance), .bypass_mask(bypass_mask),
        .out_valid(out_valid), .data_out(data_out), .data_count(data_count),
        .err_framing(err_framing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int             checks = 0;
    int             failures = 0;
    int             model_cnt = 0;
    logic [CH*W-1:0] exp_q[$];
    logic [CH*W-1:0] blk[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: block statistics and filter rule evaluated with plain integers.
    task automatic model_block(input int noise, input logic [CH-1:0] mask);
        int sum, sq, x, t, y;
        int mean_a[CH];
        int gain_a[CH];
        logic [CH*W-1:0] pix;
        for (int c = 0; c < CH; c++) begin
            int vr, sv;
            sum = 0; sq = 0;
            for (int i = 0; i < N; i++) begin
                x = int'(blk[i][c*W +: W]);
                sum += x;
                sq  += x * x;
            end
            mean_a[c] = sum / N;
            vr = sq / N - mean_a[c] * mean_a[c];
            if (vr < 0) vr = 0;
            sv = vr - noise;
            if (sv < 0) sv = 0;
            gain_a[c] = (vr == 0) ? 0 : (sv * (1 << GF)) / vr;
            if (gain_a[c] > (1 << GF)) gain_a[c] = 1 << GF;
        end
        for (int i = 0; i < N; i++) begin
            pix = '0;
            for (int c = 0; c < CH; c++) begin
                x = int'(blk[i][c*W +: W]);
                if (mask[c]) y = x;
                else begin
                    t = gain_a[c] * (x - mean_a[c]);
                    y = mean_a[c] + $rtoi($floor(real'(t) / real'(1 << GF)));
                    if (y < 0) y = 0;
                    if (y > (1 << W) - 1) y = (1 << W) - 1;
                end
                pix[c*W +: W] = y[W-1:0];
            end
            exp_q.push_back(pix);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) model_cnt = 0;
        else begin
            check("data_count", data_count, model_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out_valid actual=%0h expected=no_output at %0t", data_out, $time);
                end else check("data_out", data_out, exp_q.pop_front());
            end
            model_cnt = start_of_frame ? (out_valid ? 1 : 0) : model_cnt + (out_valid ? 1 : 0);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CH*W-1:0] pix, input logic sd);
        tick;
        in_valid = 1'b1;
        start_data = sd;
        data_in = pix;
    endtask

    task automatic send_blk;
        for (int i = 0; i < N; i++) drive(blk[i], i == 0);
    endtask

    task automatic pulse_sof;
        tick; start_of_frame = 1'b1;
        tick; start_of_frame = 1'b0;
    endtask

    // Called right after the last sample has been driven; sof_beat>0 pulses
    // start_of_frame during that output beat.
    task automatic await_block(input string tag, input logic [CH*W-1:0] first_exp, input int sof_beat);
        int n, m, b;
        tick;
        in_valid = 1'b0;
        start_data = 1'b0;
        n = 1;
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        while (!out_valid && n < 200) begin tick; n++; end
        check({tag, "_latency"}, n, 32'd29);
        check({tag, "_first_pixel"}, 32'(data_out), 32'(first_exp));
        m = 0; b = 1;
        while (!in_ready && m < 200) begin
            start_of_frame = (b == sof_beat);
            tick; m++; b++;
        end
        start_of_frame = 1'b0;
        check({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic fill_const(input logic [W-1:0] v);
        for (int i = 0; i < N; i++) blk[i] = {CH{v}};
    endtask

    task automatic fill_alt;
        for (int i = 0; i < N; i++) blk[i] = (i % 2 == 1) ? {CH{8'd110}} : {CH{8'd90}};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b1; start_of_frame = 1'b0; start_data = 1'b0; in_valid = 1'b0;
        data_in = '0; noise_variance = '0; bypass_mask = '0;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_count", data_count, 32'd0);
        check("rst_err_framing", 32'(err_framing), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // accepts before the first start_data are discarded
        for (int i = 0; i < 3; i++) drive({CH{8'hFF}}, 1'b0);
        noise_variance = 16'd10;
        fill_const(8'd100);
        model_block(10, '0);
        send_blk();
        await_block("const", 24'h646464, 0);
        check("const_count", data_count, 32'd64);
        check("const_no_err", 32'(err_framing), 32'd0);

        fill_alt();
        noise_variance = 16'd0;
        model_block(0, '0);
        send_blk();
        await_block("alt_n0", 24'h5A5A5A, 0);

        noise_variance = 16'd50;
        model_block(50, '0);
        send_blk();
        await_block("alt_n50", 24'h5F5F5F, 0);

        // start_of_frame on output beat 10: count restarts at 1
        noise_variance = 16'd200;
        model_block(200, '0);
        send_blk();
        await_block("alt_n200", 24'h646464, 10);
        check("sof_mid_count", data_count, 32'd55);

        noise_variance = 16'd50;
        bypass_mask = 3'b010;
        model_block(50, 3'b010);
        send_blk();
        await_block("bypass", 24'h5F5A5F, 0);
        bypass_mask = '0;

        pulse_sof();
        check("sof_clears_count", data_count, 32'd0);

        // framing error: start_data again at index 10
        drive({CH{8'd200}}, 1'b1);
        for (int i = 1; i < 10; i++) drive({CH{8'd200}}, 1'b0);
        fill_alt();
        model_block(50, '0);
        send_blk();
        await_block("framing", 24'h5F5F5F, 0);
        check("framing_err_set", 32'(err_framing), 32'd1);
        pulse_sof();
        check("framing_err_cleared", 32'(err_framing), 32'd0);

        // reset asserted on the 20th output beat
        model_block(50, '0);
        send_blk();
        tick;
        in_valid = 1'b0; start_data = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin tick; n++; end
        repeat (19) tick;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_data_count", data_count, 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick; tick;
        rst_n = 1'b1;

        noise_variance = 16'd0;
        model_block(0, '0);
        send_blk();
        await_block("post_rst", 24'h5A5A5A, 0);
        check("post_rst_count", data_count, 32'd64);
        check("queue_drained", exp_q.size(), 32'd0);

        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
